dl_proc_token_monitor: RTL and testbench

//  Per-process deadlock monitor: the sending end of the deadlock-detection vector. One instance per dataflow process.
//  It drives that process's bit of the report unit's dl_in_vec and forwards the cycle-trace token to the process it is blocked on.

---
 rtl/dl_proc_token_monitor.sv | 208 ++++++++++++++++++++
 tb/tb_dl_proc_token_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_proc_token_monitor.sv
// Per-process deadlock monitor: filters the raw stall into a stable "blocked" flag,
// reports it during detection, and forwards the cycle-trace token to the blocking peer.
module dl_proc_token_monitor #(
  parameter int unsigned                PROC_NUM      = 4,
  parameter int unsigned                PROC_ID       = 0,
  parameter int unsigned                CHAN_NUM      = 2,
  parameter logic [CHAN_NUM*8-1:0]      CHAN_PEER_MAP = '0,
  parameter int unsigned                BLK_THRESH    = 16
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic                proc_idle,
  input  logic [CHAN_NUM-1:0] chan_blk,
  input  logic                dl_detect_in,
  input  logic [PROC_NUM-1:0] origin,
  input  logic                token_in,
  input  logic                token_clear,
  output logic                dl_out,
  output logic [PROC_NUM-1:0] token_out,
  output logic [7:0]          chan_sel,
  output logic                blocked,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLOSE = 2'd3
  } state_e;

  localparam logic [15:0] THRESH = 16'(BLK_THRESH);
  localparam logic [7:0]  SELF   = 8'(PROC_ID);

  // Lowest-numbered stalled channel; 0 when nothing is stalled.
  function automatic logic [7:0] lowest_blk(input logic [CHAN_NUM-1:0] v);
    lowest_blk = '0;
    for (int c = int'(CHAN_NUM) - 1; c >= 0; c--) begin
      if (v[c]) lowest_blk = 8'(c);
    end
  endfunction

  function automatic logic [7:0] peer_of(input logic [7:0] sel);
    peer_of = '0;
    for (int c = 0; c < int'(CHAN_NUM); c++) begin
      if (sel == 8'(c)) peer_of = CHAN_PEER_MAP[c*8 +: 8];
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Blocked filter
  // ---------------------------------------------------------------------------
  logic        raw_blk;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic        blocked_q, blocked_d;

  assign raw_blk = ~proc_idle & (|chan_blk);

  always_comb begin
    blk_cnt_d = '0;
    if (raw_blk) begin
      blk_cnt_d = (blk_cnt_q == THRESH) ? blk_cnt_q : blk_cnt_q + 16'd1;
    end
  end

  // Qualifying with raw_blk makes the flag drop on the first edge after the stall ends.
  assign blocked_d = raw_blk & (blk_cnt_q == THRESH);

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      blk_cnt_q <= '0;
      blocked_q <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blocked_q <= blocked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Token trace FSM
  // Token protocol: origin and token_in are single-cycle pulses that are taken
  // only in IDLE while detection is active and the process is stably blocked;
  // a pulse that is not taken is lost (the report unit stalls). token_out is a
  // single-cycle one-hot pulse emitted in HOLD with no acknowledge; token_clear
  // from the report unit closes any trace in progress.
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic                  is_origin_q, is_origin_d;
  logic [7:0]            chan_sel_q, chan_sel_d;
  logic                  dl_out_q, dl_out_d;
  logic [PROC_NUM-1:0]   token_out_q, token_out_d;
  logic                  own_origin;
  logic                  start_trace;
  logic                  abort_trace;
  logic [7:0]            peer_d;

  assign own_origin  = origin[PROC_ID];
  assign start_trace = dl_detect_in & blocked_q & (own_origin | token_in);
  assign abort_trace = ~dl_detect_in | token_clear;

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      state_q     <= ST_IDLE;
      is_origin_q <= 1'b0;
      chan_sel_q  <= '0;
      dl_out_q    <= 1'b0;
      token_out_q <= '0;
    end else begin
      state_q     <= state_d;
      is_origin_q <= is_origin_d;
      chan_sel_q  <= chan_sel_d;
      dl_out_q    <= dl_out_d;
      token_out_q <= token_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    chan_sel_d  = chan_sel_q;
    is_origin_d = is_origin_q;

    if (state_q == ST_IDLE) begin
      is_origin_d = own_origin;
    end else if (token_clear) begin
      is_origin_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_trace) begin
          state_d    = ST_HOLD;
          chan_sel_d = lowest_blk(chan_blk);
        end
      end
      ST_HOLD: begin
        if (abort_trace) begin
          state_d = ST_IDLE;
        end else if (peer_of(chan_sel_q) == SELF) begin
          state_d = ST_CLOSE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort_trace) begin
          state_d = ST_IDLE;
        end else if (token_in & is_origin_q) begin
          state_d = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    dl_out_d    = 1'b0;
    token_out_d = '0;
    peer_d      = peer_of(chan_sel_d);
    case (state_d)
      ST_IDLE: begin
        dl_out_d = blocked_d & ~dl_detect_in;
      end
      ST_HOLD: begin
        dl_out_d = ~is_origin_d;
        for (int p = 0; p < int'(PROC_NUM); p++) begin
          token_out_d[p] = (peer_d == 8'(p)) && (peer_d != SELF);
        end
      end
      ST_CLOSE: begin
        dl_out_d = 1'b1;
      end
      default: begin
        dl_out_d = 1'b0;
      end
    endcase
  end

  assign dl_out    = dl_out_q;
  assign token_out = token_out_q;
  assign chan_sel  = chan_sel_q;
  assign blocked   = blocked_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_tok_onehot: assert property (@(posedge dl_clock) disable iff (!dl_reset)
    $onehot0(token_out));

  a_tok_only_hold: assert property (@(posedge dl_clock) disable iff (!dl_reset)
    (token_out != '0) |-> (state_q == ST_HOLD));

  a_hold_single: assert property (@(posedge dl_clock) disable iff (!dl_reset)
    (state_q == ST_HOLD) |=> (state_q != ST_HOLD));

  a_close_single: assert property (@(posedge dl_clock) disable iff (!dl_reset)
    (state_q == ST_CLOSE) |=> (state_q == ST_IDLE));

  a_cnt_bound: assert property (@(posedge dl_clock) disable iff (!dl_reset)
    blk_cnt_q <= THRESH);

endmodule

// File: tb/tb_dl_proc_token_monitor.sv
// Bench for dl_proc_token_monitor: two instances (PROC_ID 0 and 2) share one stimulus stream
// and are checked against a trace-level reference model, plus directed table rows.
module tb_dl_proc_token_monitor;
  localparam int PROC_NUM = 4;
  localparam int CHAN_NUM = 2;
  localparam int THRESH   = 4;
  localparam int N_INST   = 2;
  localparam int W        = 14;

  localparam int PH_IDLE  = 0;
  localparam int PH_HOLD  = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_CLOSE = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic                dl_clock = 1'b0;
  logic                dl_reset = 1'b1;
  logic                proc_idle = 1'b0;
  logic [CHAN_NUM-1:0] chan_blk = '0;
  logic                dl_detect_in = 1'b0;
  logic [PROC_NUM-1:0] origin = '0;
  logic                token_in = 1'b0;
  logic                token_clear = 1'b0;

  logic                dl_out0, dl_out1;
  logic [PROC_NUM-1:0] token_out0, token_out1;
  logic [7:0]          chan_sel0, chan_sel1;
  logic                blocked0, blocked1;
  logic [1:0]          dbg_state0, dbg_state1;

  always #5 dl_clock = ~dl_clock;

  dl_proc_token_monitor #(
    .PROC_NUM(PROC_NUM), .PROC_ID(0), .CHAN_NUM(CHAN_NUM),
    .CHAN_PEER_MAP(16'h0302), .BLK_THRESH(THRESH)
  ) u_dut0 (
    .dl_clock(dl_clock), .dl_reset(dl_reset), .proc_idle(proc_idle), .chan_blk(chan_blk),
    .dl_detect_in(dl_detect_in), .origin(origin), .token_in(token_in), .token_clear(token_clear),
    .dl_out(dl_out0), .token_out(token_out0), .chan_sel(chan_sel0), .blocked(blocked0),
    .dbg_state(dbg_state0)
  );

  dl_proc_token_monitor #(
    .PROC_NUM(PROC_NUM), .PROC_ID(2), .CHAN_NUM(CHAN_NUM),
    .CHAN_PEER_MAP(16'h0201), .BLK_THRESH(THRESH)
  ) u_dut1 (
    .dl_clock(dl_clock), .dl_reset(dl_reset), .proc_idle(proc_idle), .chan_blk(chan_blk),
    .dl_detect_in(dl_detect_in), .origin(origin), .token_in(token_in), .token_clear(token_clear),
    .dl_out(dl_out1), .token_out(token_out1), .chan_sel(chan_sel1), .blocked(blocked1),
    .dbg_state(dbg_state1)
  );

  // ---------------------------------------------------------------------------
  // Counters and checker
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;
  int step_no = 0;

  function automatic void check(string name, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, step_no, got, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: stall run length and trace phase per instance
  // ---------------------------------------------------------------------------
  int   pid[N_INST]                = '{0, 2};
  int   peer_map[N_INST][CHAN_NUM] = '{'{2, 3}, '{1, 2}};
  int   m_run[N_INST];
  int   m_phase[N_INST];
  int   m_sel[N_INST];
  logic m_orig[N_INST];
  logic m_blk[N_INST];

  logic [W-1:0] exp_q[$];

  function automatic void model_reset();
    for (int k = 0; k < N_INST; k++) begin
      m_run[k] = 0; m_phase[k] = PH_IDLE; m_sel[k] = 0; m_orig[k] = 1'b0; m_blk[k] = 1'b0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_step();
    for (int k = 0; k < N_INST; k++) begin
      logic       raw, blk_prev, blk_new, own_org, dl_e;
      logic [3:0] tok_e;
      int         peer;
      raw      = !proc_idle && (chan_blk != 2'b00);
      blk_prev = m_blk[k];
      m_run[k] = raw ? m_run[k] + 1 : 0;
      blk_new  = (m_run[k] >= THRESH + 1);
      own_org  = origin[pid[k]];
      if (m_phase[k] == PH_IDLE) begin
        m_orig[k] = own_org;
        if (dl_detect_in && blk_prev && (own_org || token_in)) begin
          m_sel[k]   = chan_blk[0] ? 0 : (chan_blk[1] ? 1 : 0);
          m_phase[k] = PH_HOLD;
        end
      end else if (!dl_detect_in) begin
        m_phase[k] = PH_IDLE;
        if (token_clear) m_orig[k] = 1'b0;
      end else if (token_clear) begin
        m_phase[k] = PH_IDLE;
        m_orig[k]  = 1'b0;
      end else if (m_phase[k] == PH_HOLD) begin
        m_phase[k] = (peer_map[k][m_sel[k]] == pid[k]) ? PH_CLOSE : PH_WAIT;
      end else if (m_phase[k] == PH_WAIT) begin
        if (token_in && m_orig[k]) m_phase[k] = PH_CLOSE;
      end else begin
        m_phase[k] = PH_IDLE;
      end
      m_blk[k] = blk_new;
      peer  = peer_map[k][m_sel[k]];
      dl_e  = 1'b0;
      tok_e = 4'b0000;
      if (m_phase[k] == PH_IDLE)  dl_e = blk_new && !dl_detect_in;
      if (m_phase[k] == PH_CLOSE) dl_e = 1'b1;
      if (m_phase[k] == PH_HOLD) begin
        dl_e = !m_orig[k];
        if (peer != pid[k]) tok_e = 4'b0001 << peer;
      end
      exp_q.push_back({blk_new, dl_e, tok_e, 8'(m_sel[k])});
    end
  endfunction

  function automatic logic [W-1:0] dut_vec(int k);
    if (k == 0) return {blocked0, dl_out0, token_out0, chan_sel0};
    return {blocked1, dl_out1, token_out1, chan_sel1};
  endfunction

  function automatic void scoreboard_check();
    for (int k = 0; k < N_INST; k++) begin
      logic [W-1:0] exp, got;
      exp = exp_q.pop_front();
      got = dut_vec(k);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL sb inst%0d (step %0d): got blk=%0b dl=%0b tok=%b sel=%0d, expected blk=%0b dl=%0b tok=%b sel=%0d",
                 k, step_no, got[13], got[12], got[11:8], got[7:0], exp[13], exp[12], exp[11:8], exp[7:0]);
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: called at a negedge, returns at the next negedge
  // ---------------------------------------------------------------------------
  task automatic step(input logic idle, input logic [1:0] cb, input logic det,
                      input logic [3:0] org, input logic tin, input logic tclr);
    proc_idle    = idle;
    chan_blk     = cb;
    dl_detect_in = det;
    origin       = org;
    token_in     = tin;
    token_clear  = tclr;
    model_step();
    @(posedge dl_clock);
    #1;
    step_no++;
    scoreboard_check();
    @(negedge dl_clock);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (expected values are for instance 0)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       idle;
    logic [1:0] cb;
    logic       det;
    logic [3:0] org;
    logic       tin;
    logic       tclr;
    logic       e_blk;
    logic       e_dl;
    logic [3:0] e_tok;
    logic [7:0] e_sel;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic idle, logic [1:0] cb, logic det, logic [3:0] org, logic tin,
                              logic tclr, logic e_blk, logic e_dl, logic [3:0] e_tok, logic [7:0] e_sel);
    vec_t v;
    v.idle = idle; v.cb = cb; v.det = det; v.org = org; v.tin = tin; v.tclr = tclr;
    v.e_blk = e_blk; v.e_dl = e_dl; v.e_tok = e_tok; v.e_sel = e_sel;
    tbl.push_back(v);
  endfunction

  logic [1:0] r_cb;
  logic       r_idle, r_det;
  logic [3:0] r_org;

  initial begin
    // filter: rises on the 5th edge, a 1-cycle gap restarts it, idle masks the stall
    for (int i = 0; i < 4; i++) add(0, 2'b01, 0, 4'h0, 0, 0, 0, 0, 4'h0, 8'd0);
    add(0, 2'b01, 0, 4'h0, 0, 0, 1, 1, 4'h0, 8'd0);
    add(0, 2'b00, 0, 4'h0, 0, 0, 0, 0, 4'h0, 8'd0);
    for (int i = 0; i < 3; i++) add(0, 2'b01, 0, 4'h0, 0, 0, 0, 0, 4'h0, 8'd0);
    add(0, 2'b00, 0, 4'h0, 0, 0, 0, 0, 4'h0, 8'd0);
    for (int i = 0; i < 4; i++) add(0, 2'b01, 0, 4'h0, 0, 0, 0, 0, 4'h0, 8'd0);
    add(0, 2'b01, 0, 4'h0, 0, 0, 1, 1, 4'h0, 8'd0);
    for (int i = 0; i < 6; i++) add(1, 2'b11, 0, 4'h0, 0, 0, 0, 0, 4'h0, 8'd0);
    // detection then origin trace through channel 1 to peer 3
    for (int i = 0; i < 4; i++) add(0, 2'b01, 0, 4'h0, 0, 0, 0, 0, 4'h0, 8'd0);
    add(0, 2'b01, 0, 4'h0, 0, 0, 1, 1, 4'h0, 8'd0);
    add(0, 2'b01, 1, 4'h0, 0, 0, 1, 0, 4'h0, 8'd0);
    add(0, 2'b10, 1, 4'h1, 0, 0, 1, 0, 4'h8, 8'd1);
    for (int i = 0; i < 5; i++) add(0, 2'b10, 1, 4'h0, 0, 0, 1, 0, 4'h0, 8'd1);
    add(0, 2'b10, 1, 4'h0, 1, 0, 1, 1, 4'h0, 8'd1);
    add(0, 2'b10, 1, 4'h0, 0, 0, 1, 0, 4'h0, 8'd1);
    add(0, 2'b10, 0, 4'h0, 0, 0, 1, 1, 4'h0, 8'd1);
    // detection dropped while waiting
    add(0, 2'b10, 1, 4'h1, 0, 0, 1, 0, 4'h8, 8'd1);
    add(0, 2'b10, 1, 4'h0, 0, 0, 1, 0, 4'h0, 8'd1);
    add(0, 2'b10, 0, 4'h0, 0, 0, 1, 1, 4'h0, 8'd1);

    // reset state
    model_reset();
    #2 dl_reset = 1'b0;
    @(negedge dl_clock);
    @(negedge dl_clock);
    check("reset inst0", 16'(dut_vec(0)), 16'h0);
    check("reset inst1", 16'(dut_vec(1)), 16'h0);
    check("reset fsm", 16'({dbg_state0, dbg_state1}), 16'h0);
    dl_reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].idle, tbl[i].cb, tbl[i].det, tbl[i].org, tbl[i].tin, tbl[i].tclr);
      check($sformatf("tbl%0d blocked", i), 16'(blocked0), 16'(tbl[i].e_blk));
      check($sformatf("tbl%0d dl_out", i), 16'(dl_out0), 16'(tbl[i].e_dl));
      check($sformatf("tbl%0d token_out", i), 16'(token_out0), 16'(tbl[i].e_tok));
      check($sformatf("tbl%0d chan_sel", i), 16'(chan_sel0), 16'(tbl[i].e_sel));
    end

    // async reset while holding the token
    step(0, 2'b10, 1, 4'h1, 0, 0);
    check("hold before reset tok", 16'(token_out0), 16'h8);
    #1 dl_reset = 1'b0;
    #1;
    check("async reset inst0", 16'(dut_vec(0)), 16'h0);
    check("async reset inst1", 16'(dut_vec(1)), 16'h0);
    model_reset();
    proc_idle = 0; chan_blk = '0; dl_detect_in = 0; origin = '0; token_in = 0; token_clear = 0;
    @(negedge dl_clock);
    dl_reset = 1'b1;

    // mid-trace on instance 1: forward, ignore second token, clear
    for (int i = 0; i < 5; i++) step(0, 2'b01, 0, 4'h0, 0, 0);
    check("restart blocked", 16'(blocked1), 16'h1);
    step(0, 2'b01, 1, 4'h0, 0, 0);
    check("detect silences dl", 16'(dl_out1), 16'h0);
    step(0, 2'b01, 1, 4'h0, 1, 0);
    check("mid hold dl", 16'(dl_out1), 16'h1);
    check("mid hold tok", 16'(token_out1), 16'h2);
    step(0, 2'b01, 1, 4'h0, 0, 0);
    check("mid wait tok", 16'(token_out1), 16'h0);
    step(0, 2'b01, 1, 4'h0, 1, 0);
    check("second token ignored", 16'({dl_out1, token_out1}), 16'h0);
    step(0, 2'b01, 1, 4'h0, 0, 1);
    step(0, 2'b01, 1, 4'h0, 1, 0);
    check("clear back to idle", 16'(token_out1), 16'h2);
    step(0, 2'b01, 1, 4'h0, 0, 1);

    // origin and token together; clear and token together
    step(0, 2'b01, 1, 4'h1, 1, 0);
    check("origin wins dl", 16'(dl_out0), 16'h0);
    check("origin wins tok", 16'(token_out0), 16'h4);
    step(0, 2'b01, 1, 4'h0, 0, 0);
    step(0, 2'b01, 1, 4'h0, 1, 1);
    check("clear beats token", 16'(dl_out0), 16'h0);
    step(0, 2'b01, 1, 4'h0, 0, 0);
    check("no close after clear", 16'(dl_out0), 16'h0);

    // self-loop on instance 1 (channel 1 maps back to itself)
    step(0, 2'b10, 1, 4'h0, 1, 0);
    check("self hold tok", 16'(token_out1), 16'h0);
    check("self hold sel", 16'(chan_sel1), 16'h1);
    step(0, 2'b10, 1, 4'h0, 0, 0);
    check("self close dl", 16'(dl_out1), 16'h1);
    step(0, 2'b10, 1, 4'h0, 0, 0);
    check("self back idle", 16'(dl_out1), 16'h0);

    // random stimulus against the model
    r_cb = 2'b01; r_idle = 1'b0; r_det = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) r_cb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) r_idle = ~r_idle;
      if ($urandom_range(0, 39) == 0) r_det = ~r_det;
      r_org = ($urandom_range(0, 9) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      step(r_idle, r_cb, r_det, r_org, ($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: run did not complete within 500000 time units");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
